frame_loader: RTL and testbench

FRAME_LOADER -- requirements
Module: frame_loader

---
 rtl/frame_loader.sv | 134 +++++++++++++
 tb/tb_frame_loader.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/frame_loader.sv
// Frame loader: accepts a raster-order pixel stream and writes one frame into frame memory.
// Optional build macro FRAME_LOADER_SOF_RESYNC_EN: a mid-frame start-of-frame restarts the frame at address 0.
module frame_loader #(
    parameter int BITS    = 8,
    parameter int ADDRLEN = 19,
    parameter int ROW     = 480,
    parameter int COL     = 640
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic [BITS-1:0]    in_pixel,
    output logic               in_ready,
    input  logic               frame_release,
    output logic               mem_wen,
    output logic [ADDRLEN-1:0] mem_waddr,
    output logic [BITS-1:0]    mem_wdata,
    output logic               frame_done,
    output logic               sync_err
);

    // state | meaning
    // IDLE  | waiting for a start-of-frame beat
    // LOAD  | writing pixels, addr_q is the next write address
    // DONE  | full frame held in memory until frame_release
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDRLEN-1:0] LAST_ADDR = ADDRLEN'(ROW * COL - 1);

    state_t             state_q, state_d;
    logic [ADDRLEN-1:0] addr_q, addr_d;
    logic               mem_wen_q, mem_wen_d;
    logic [ADDRLEN-1:0] mem_waddr_q, mem_waddr_d;
    logic [BITS-1:0]    mem_wdata_q, mem_wdata_d;
    logic               frame_done_q, frame_done_d;
    logic               sync_err_q, sync_err_d;
    logic               accept;
    logic               resync;

    assign in_ready = (state_q != DONE);
    assign accept   = in_valid && in_ready;

`ifdef FRAME_LOADER_SOF_RESYNC_EN
    assign resync = in_sof;
`else
    assign resync = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mem_wen_d   = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        sync_err_d  = sync_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_sof) begin
                        mem_wen_d   = 1'b1;
                        mem_waddr_d = '0;
                        mem_wdata_d = in_pixel;
                        addr_d      = ADDRLEN'(1);
                        state_d     = LOAD;
                    end else begin
                        sync_err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    mem_wen_d   = 1'b1;
                    mem_wdata_d = in_pixel;
                    if (resync) begin
                        sync_err_d  = 1'b1;
                        mem_waddr_d = '0;
                        addr_d      = ADDRLEN'(1);
                    end else begin
                        mem_waddr_d = addr_q;
                        if (addr_q == LAST_ADDR) begin
                            addr_d  = '0;
                            state_d = DONE;
                        end else begin
                            addr_d = addr_q + ADDRLEN'(1);
                        end
                    end
                end
            end
            DONE: begin
                if (frame_release) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                addr_d  = '0;
            end
        endcase
        // frame_done tracks the next state so it rises alongside the last write
        frame_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            mem_wen_q    <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            mem_wen_q    <= mem_wen_d;
            mem_waddr_q  <= mem_waddr_d;
            mem_wdata_q  <= mem_wdata_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign mem_wen    = mem_wen_q;
    assign mem_waddr  = mem_waddr_q;
    assign mem_wdata  = mem_wdata_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_frame_loader.sv
// Self-checking bench for frame_loader with a 4x5 frame (N=20).
module tb_frame_loader;

    localparam int BITS    = 8;
    localparam int ADDRLEN = 5;
    localparam int ROW     = 4;
    localparam int COL     = 5;
    localparam int N       = ROW * COL;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_sof;
    logic [BITS-1:0]    in_pixel;
    logic               in_ready;
    logic               frame_release;
    logic               mem_wen;
    logic [ADDRLEN-1:0] mem_waddr;
    logic [BITS-1:0]    mem_wdata;
    logic               frame_done;
    logic               sync_err;

    int checks   = 0;
    int failures = 0;

    frame_loader #(.BITS(BITS), .ADDRLEN(ADDRLEN), .ROW(ROW), .COL(COL)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_sof        (in_sof),
        .in_pixel      (in_pixel),
        .in_ready      (in_ready),
        .frame_release (frame_release),
        .mem_wen       (mem_wen),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .frame_done    (frame_done),
        .sync_err      (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       valid;
        logic       sof;
        logic [7:0] pixel;
        logic       rel;
        logic       wen;
        logic [4:0] waddr;
        logic [7:0] wdata;
        logic       done;
        logic       ready;
        logic       err;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic step(input logic r, input logic v, input logic s, input logic [7:0] p, input logic rel);
        rst = r; in_valid = v; in_sof = s; in_pixel = p; frame_release = rel;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic wen, input logic [4:0] waddr,
                              input logic [7:0] wdata, input logic done, input logic ready,
                              input logic err, input logic chk_wr);
        check({name, ".wen"}, 32'(mem_wen), 32'(wen));
        if (chk_wr) begin
            check({name, ".waddr"}, 32'(mem_waddr), 32'(waddr));
            check({name, ".wdata"}, 32'(mem_wdata), 32'(wdata));
        end
        check({name, ".done"}, 32'(frame_done), 32'(done));
        check({name, ".ready"}, 32'(in_ready), 32'(ready));
        check({name, ".err"}, 32'(sync_err), 32'(err));
    endtask

    // One full frame, pixel = index + base; optional idle cycle after every beat.
    task automatic run_frame(input string name, input logic [7:0] base, input logic stall);
        int rises;
        logic prev_done;
        rises = 0;
        prev_done = frame_done;
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, (i == 0), 8'(i) + base, 1'b0);
            expect_out($sformatf("%s.beat%0d", name, i), 1'b1, 5'(i), 8'(i) + base,
                       (i == N - 1), (i != N - 1), 1'b0, 1'b1);
            if (frame_done && !prev_done) rises++;
            prev_done = frame_done;
            if (stall) begin
                step(1'b0, 1'b0, 1'b0, 8'hEE, 1'b0);
                check($sformatf("%s.gap%0d.wen", name, i), 32'(mem_wen), 32'd0);
                check($sformatf("%s.gap%0d.done", name, i), 32'(frame_done), 32'(i == N - 1));
                if (frame_done && !prev_done) rises++;
                prev_done = frame_done;
            end
        end
        check({name, ".done_rises"}, 32'(rises), 32'd1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; frame_release = 1'b0;

        //           rst  vld  sof  pix    rel   wen  waddr wdata  done rdy  err
        vecs[0] = '{1'b1,1'b1,1'b1,8'hAA,1'b0, 1'b0,5'd0, 8'h00,1'b0,1'b1,1'b0};
        vecs[1] = '{1'b0,1'b0,1'b0,8'h00,1'b0, 1'b0,5'd0, 8'h00,1'b0,1'b1,1'b0};
        vecs[2] = '{1'b0,1'b1,1'b0,8'h11,1'b0, 1'b0,5'd0, 8'h00,1'b0,1'b1,1'b1};
        vecs[3] = '{1'b0,1'b1,1'b0,8'h12,1'b0, 1'b0,5'd0, 8'h00,1'b0,1'b1,1'b1};
        vecs[4] = '{1'b0,1'b1,1'b0,8'h13,1'b0, 1'b0,5'd0, 8'h00,1'b0,1'b1,1'b1};
        vecs[5] = '{1'b0,1'b1,1'b1,8'h55,1'b0, 1'b1,5'd0, 8'h55,1'b0,1'b1,1'b1};
        vecs[6] = '{1'b0,1'b0,1'b0,8'h00,1'b1, 1'b0,5'd0, 8'h55,1'b0,1'b1,1'b1};
        vecs[7] = '{1'b0,1'b1,1'b0,8'h56,1'b0, 1'b1,5'd1, 8'h56,1'b0,1'b1,1'b1};
        vecs[8] = '{1'b1,1'b1,1'b0,8'h57,1'b0, 1'b0,5'd0, 8'h00,1'b0,1'b1,1'b0};

        @(posedge clk); #1;
        for (int i = 0; i < 9; i++) begin
            step(vecs[i].rst, vecs[i].valid, vecs[i].sof, vecs[i].pixel, vecs[i].rel);
            expect_out($sformatf("vec%0d", i), vecs[i].wen, vecs[i].waddr, vecs[i].wdata,
                       vecs[i].done, vecs[i].ready, vecs[i].err, 1'b1);
        end

        // Continuous frame
        run_frame("cont", 8'd0, 1'b0);

        // DONE ignores beats, then release returns to IDLE
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, (i == 0), 8'h77, 1'b0);
            expect_out($sformatf("hold%0d", i), 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        expect_out("release", 1'b0, 5'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Stalled frame
        run_frame("stall", 8'd100, 1'b1);
        step(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        expect_out("release2", 1'b0, 5'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Start-of-frame on beat 7
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, (i == 0), 8'(i + 40), 1'b0);
            expect_out($sformatf("sof7.beat%0d", i), 1'b1, 5'(i), 8'(i + 40), 1'b0, 1'b1, 1'b0, 1'b1);
        end
        step(1'b0, 1'b1, 1'b1, 8'd47, 1'b0);
`ifdef FRAME_LOADER_SOF_RESYNC_EN
        expect_out("sof7.resync", 1'b1, 5'd0, 8'd47, 1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'd48, 1'b0);
        expect_out("sof7.next", 1'b1, 5'd1, 8'd48, 1'b0, 1'b1, 1'b1, 1'b1);
`else
        expect_out("sof7.ignored", 1'b1, 5'd7, 8'd47, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'd48, 1'b0);
        expect_out("sof7.next", 1'b1, 5'd8, 8'd48, 1'b0, 1'b1, 1'b0, 1'b1);
`endif

        // Mid-frame reset, then a clean frame loads from address 0
        step(1'b1, 1'b1, 1'b0, 8'd49, 1'b0);
        expect_out("midrst", 1'b0, 5'd0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        run_frame("after_rst", 8'd200, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
